// File: rtl/data_store_buffer_pkg.sv
// Shared widths, buffer depth and port-arbitration encoding for the data-side
// store buffer and its data memory.
package data_store_buffer_pkg;

    localparam int DSB_DATA_WIDTH = 32;
    localparam int DSB_ADDR_WIDTH = 32;
    localparam int DSB_DEPTH      = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOAD  = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_e;

    // Pointer width for a power-of-two FIFO; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int PTR_W = ptr_width(DSB_DEPTH);

endpackage

// File: rtl/data_store_buffer_if.sv
// MEM-stage request/response and memory-port signals of the store buffer.
// slave is the buffer's view; master is the view of the pipeline plus RAM.
interface data_store_buffer_if
    import data_store_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DSB_DATA_WIDTH,
    parameter int ADDR_WIDTH = DSB_ADDR_WIDTH
);
    logic                  st_valid;
    logic                  st_ready;
    logic [ADDR_WIDTH-1:0] st_addr;
    logic [DATA_WIDTH-1:0] st_data;

    logic                  ld_valid;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_data_valid;

    logic                  flush;
    logic                  empty;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  st_valid, st_addr, st_data,
        input  ld_valid, ld_addr,
        input  flush,
        input  mem_rdata,
        output st_ready, ld_data, ld_data_valid, empty,
        output mem_we, mem_addr, mem_wdata
    );

    modport master (
        output st_valid, st_addr, st_data,
        output ld_valid, ld_addr,
        output flush,
        output mem_rdata,
        input  st_ready, ld_data, ld_data_valid, empty,
        input  mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/data_store_buffer_match.sv
// Combinational youngest-match search over the valid store-buffer entries,
// walking from head (oldest) toward tail so the last hit wins.
module data_store_buffer_match
    import data_store_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DSB_DATA_WIDTH,
    parameter int ADDR_WIDTH = DSB_ADDR_WIDTH,
    parameter int DEPTH      = DSB_DEPTH,
    localparam int PW        = ptr_width(DEPTH),
    localparam int CW        = PW + 1
) (
    input  logic [ADDR_WIDTH-1:0] entry_addr [DEPTH],
    input  logic [DATA_WIDTH-1:0] entry_data [DEPTH],
    input  logic [PW-1:0]         head,
    input  logic [CW-1:0]         count,
    input  logic [ADDR_WIDTH-1:0] query_addr,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] hit_data
);

    // Indexed by age offset from head, not by physical slot.
    logic [DEPTH-1:0]      off_match;
    logic [DATA_WIDTH-1:0] off_data [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_off
            logic [PW-1:0] slot;
            logic          live;

            assign slot           = head + PW'(gi);
            assign live           = CW'(gi) < count;
            assign off_match[gi]  = live && (entry_addr[slot] == query_addr);
            assign off_data[gi]   = entry_data[slot];
        end
    endgenerate

    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (off_match[i]) begin
                hit      = 1'b1;
                hit_data = off_data[i];
            end
        end
    end

endmodule

// File: rtl/data_store_buffer.sv
// In-order store buffer in front of a single-port data RAM: loads own the port
// and are forwarded from buffered stores; stores drain on every load-free cycle.
module data_store_buffer
    import data_store_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DSB_DATA_WIDTH,
    parameter int ADDR_WIDTH = DSB_ADDR_WIDTH,
    parameter int DEPTH      = DSB_DEPTH
) (
    input logic                clk,
    input logic                reset,
    data_store_buffer_if.slave bus
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] entry_addr_reg [DEPTH];
    logic [DATA_WIDTH-1:0] entry_data_reg [DEPTH];

    logic [PW-1:0]         head_reg;
    logic [PW-1:0]         head_next;
    logic [PW-1:0]         tail_reg;
    logic [PW-1:0]         tail_next;
    logic [CW-1:0]         count_reg;
    logic [CW-1:0]         count_next;

    arb_e                  arb;
    logic                  push;
    logic                  pop;

    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;

    logic                  ld_valid_reg;
    logic                  hit_reg;
    logic [DATA_WIDTH-1:0] fwd_data_reg;

    // Ready looks only at the registered count, so a full buffer never
    // accepts even when the same cycle drains an entry.
    assign bus.st_ready = count_reg < CW'(DEPTH);
    assign bus.empty    = (count_reg == '0);
    assign push         = bus.st_valid && bus.st_ready;

    always_comb begin
        arb = ARB_IDLE;
        if (bus.ld_valid) begin
            arb = ARB_LOAD;
        end else if (count_reg != '0) begin
            arb = ARB_DRAIN;
        end
    end

    assign pop = (arb == ARB_DRAIN);

    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (arb)
            ARB_LOAD: begin
                bus.mem_addr = bus.ld_addr;
            end
            ARB_DRAIN: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = entry_addr_reg[head_reg];
                bus.mem_wdata = entry_data_reg[head_reg];
            end
            default: begin
                bus.mem_we = 1'b0;
            end
        endcase
    end

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (push) begin
            tail_next = tail_reg + PW'(1);
        end
        if (pop) begin
            head_next = head_reg + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Entry payloads need no reset: count gates every use of them.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (tail_reg == PW'(gi))) begin
                    entry_addr_reg[gi] <= bus.st_addr;
                    entry_data_reg[gi] <= bus.st_data;
                end
            end
        end
    endgenerate

    // Searches only entries already registered, so a store accepted alongside
    // the load is never visible to it.
    data_store_buffer_match #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_match (
        .entry_addr (entry_addr_reg),
        .entry_data (entry_data_reg),
        .head       (head_reg),
        .count      (count_reg),
        .query_addr (bus.ld_addr),
        .hit        (fwd_hit),
        .hit_data   (fwd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_valid_reg <= 1'b0;
            hit_reg      <= 1'b0;
            fwd_data_reg <= '0;
        end else begin
            ld_valid_reg <= bus.ld_valid;
            hit_reg      <= bus.ld_valid && fwd_hit;
            fwd_data_reg <= fwd_data;
        end
    end

    assign bus.ld_data_valid = ld_valid_reg;
    assign bus.ld_data       = !ld_valid_reg ? '0
                             : (hit_reg ? fwd_data_reg : bus.mem_rdata);

endmodule

// File: tb/tb_data_store_buffer.sv
// Bench for data_store_buffer: RAM environment plus a program-order memory
// model and a queue of not-yet-written stores.
`timescale 1ns/1ps
module tb_data_store_buffer;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    data_store_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    data_store_buffer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } st_t;

    int unsigned   n_vec = 0;
    int unsigned   n_err = 0;

    logic [DW-1:0] ram  [logic [AW-1:0]];
    logic [DW-1:0] arch [logic [AW-1:0]];
    st_t           pend [$];
    st_t           wr_log [$];
    logic          ldp;
    logic [DW-1:0] ldp_val;
    logic          accepted;

    logic          o_we, o_ldv, o_ready, o_empty;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wdata, o_ldd;
    logic          e_we, e_ldv, e_ready, e_empty, e_chkw;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_ldd;

    function automatic logic [DW-1:0] rd_ram(input logic [AW-1:0] a);
        return ram.exists(a) ? ram[a] : '0;
    endfunction

    function automatic logic [DW-1:0] rd_arch(input logic [AW-1:0] a);
        return arch.exists(a) ? arch[a] : '0;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] hi;
        hi = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'h0;
        return hi | AW'($urandom_range(0, 7));
    endfunction

    task automatic drive(input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                         input logic lv, input logic [AW-1:0] la);
        bus.st_valid = sv;
        bus.st_addr  = sa;
        bus.st_data  = sd;
        bus.ld_valid = lv;
        bus.ld_addr  = la;
    endtask

    task automatic model_reset();
        pend.delete();
        ldp     = 1'b0;
        ldp_val = '0;
        arch    = ram;
    endtask

    // One clock: sample DUT at negedge, advance the model, then act as RAM.
    task automatic tick();
        st_t           f;
        logic [DW-1:0] rdv;
        @(negedge clk);
        o_we    = bus.mem_we;
        o_addr  = bus.mem_addr;
        o_wdata = bus.mem_wdata;
        o_ldv   = bus.ld_data_valid;
        o_ldd   = bus.ld_data;
        o_ready = bus.st_ready;
        o_empty = bus.empty;

        e_ready = pend.size() < DEPTH;
        e_empty = (pend.size() == 0);
        e_ldv   = ldp;
        e_ldd   = ldp ? ldp_val : '0;
        e_we    = 1'b0;
        e_addr  = '0;
        e_wdata = '0;
        e_chkw  = 1'b1;
        if (bus.ld_valid) begin
            e_addr = bus.ld_addr;
            e_chkw = 1'b0;
        end else if (pend.size() > 0) begin
            f       = pend.pop_front();
            e_we    = 1'b1;
            e_addr  = f.a;
            e_wdata = f.d;
        end
        ldp = bus.ld_valid;
        if (bus.ld_valid) ldp_val = rd_arch(bus.ld_addr);
        accepted = bus.st_valid && e_ready;
        if (accepted) begin
            arch[bus.st_addr] = bus.st_data;
            pend.push_back({bus.st_addr, bus.st_data});
        end
        if (o_we) wr_log.push_back({o_addr, o_wdata});

        @(posedge clk);
        rdv = rd_ram(o_addr);
        if (o_we) ram[o_addr] = o_wdata;
        bus.mem_rdata = rdv;
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0);
        bus.flush     = 1'b0;
        bus.mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty();
        drive(1'b0, '0, '0, 1'b0, '0);
        bus.flush = 1'b1;
        for (int i = 0; i < 20 && pend.size() != 0; i++) tick();
        tick();
        n_vec++;
        if (o_empty !== 1'b1 || pend.size() != 0) begin
            n_err++;
            $display("FAIL flush_empty: empty=%0b pending=%0d, required empty=1 pending=0",
                     o_empty, pend.size());
        end
        bus.flush = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        tick();
        n_vec += 3;
        if (o_ready !== 1'b1 || o_empty !== 1'b1) begin
            n_err++;
            $display("FAIL reset_status: st_ready=%0b empty=%0b, required 1 1", o_ready, o_empty);
        end
        if (o_ldv !== 1'b0 || o_ldd !== '0) begin
            n_err++;
            $display("FAIL reset_load: ld_data_valid=%0b ld_data=%h, required 0 0", o_ldv, o_ldd);
        end
        if (o_we !== 1'b0 || o_addr !== '0) begin
            n_err++;
            $display("FAIL reset_port: mem_we=%0b mem_addr=%h, required 0 0", o_we, o_addr);
        end
    endtask

    task automatic test_drain_order();
        logic [AW-1:0] ea [3] = '{32'd1, 32'd2, 32'd3};
        logic [DW-1:0] ed [3] = '{32'hA1, 32'hB2, 32'hC3};
        wr_log.delete();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ea[i], ed[i], 1'b0, '0);
            tick();
            n_vec++;
            if (o_we !== e_we || o_addr !== e_addr || o_wdata !== e_wdata) begin
                n_err++;
                $display("FAIL drain_port: we=%0b addr=%h data=%h, required we=%0b addr=%h data=%h",
                         o_we, o_addr, o_wdata, e_we, e_addr, e_wdata);
            end
        end
        wait_empty();
        n_vec++;
        if (wr_log.size() != 3) begin
            n_err++;
            $display("FAIL drain_count: %0d writes, required 3", wr_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (wr_log[i].a !== ea[i] || wr_log[i].d !== ed[i]) begin
                    n_err++;
                    $display("FAIL drain_order[%0d]: addr=%h data=%h, required addr=%h data=%h",
                             i, wr_log[i].a, wr_log[i].d, ea[i], ed[i]);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (rd_ram(ea[i]) !== ed[i]) begin
                n_err++;
                $display("FAIL ram_dump[%h]: %h, required %h", ea[i], rd_ram(ea[i]), ed[i]);
            end
        end
    endtask

    task automatic test_load_hold();
        int waited;
        wr_log.delete();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h20 + AW'(i), 32'h1000 + DW'(i), 1'b1, 32'h40);
            tick();
            n_vec += 2;
            if (o_we !== 1'b0) begin
                n_err++;
                $display("FAIL hold_no_drain cyc%0d: mem_we=%0b, required 0", i, o_we);
            end
            if (o_ldv !== e_ldv || o_ldd !== e_ldd) begin
                n_err++;
                $display("FAIL hold_b2b_load cyc%0d: valid=%0b data=%h, required %0b %h",
                         i, o_ldv, o_ldd, e_ldv, e_ldd);
            end
        end
        n_vec++;
        if (o_ready !== 1'b0) begin
            n_err++;
            $display("FAIL hold_full_ready: st_ready=%0b, required 0", o_ready);
        end
        // Fifth store stays offered until the model says it is taken.
        drive(1'b1, 32'h24, 32'h1004, 1'b0, '0);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!accepted && waited < 10);
        n_vec++;
        if (!accepted) begin
            n_err++;
            $display("FAIL hold_fifth_accept: not accepted within 10 cycles");
        end
        wait_empty();
        n_vec++;
        if (wr_log.size() != 5) begin
            n_err++;
            $display("FAIL hold_drain_count: %0d writes, required 5", wr_log.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_vec++;
                if (wr_log[i].a !== 32'h20 + AW'(i) || wr_log[i].d !== 32'h1000 + DW'(i)) begin
                    n_err++;
                    $display("FAIL hold_drain_order[%0d]: addr=%h data=%h, required addr=%h data=%h",
                             i, wr_log[i].a, wr_log[i].d, 32'h20 + AW'(i), 32'h1000 + DW'(i));
                end
            end
        end
    endtask

    task automatic test_forward();
        drive(1'b1, 32'd5, 32'd11, 1'b0, '0); tick();
        drive(1'b1, 32'd5, 32'd22, 1'b0, '0); tick();
        drive(1'b0, '0, '0, 1'b1, 32'd5);     tick();
        drive(1'b0, '0, '0, 1'b0, '0);        tick();
        n_vec++;
        if (o_ldv !== 1'b1 || o_ldd !== 32'd22) begin
            n_err++;
            $display("FAIL fwd_youngest: valid=%0b data=%0d, required 1 22 (ram holds %0d)",
                     o_ldv, o_ldd, rd_ram(32'd5));
        end
        wait_empty();
    endtask

    task automatic test_mem_read();
        ram[32'd9]  = 32'h99;
        arch[32'd9] = 32'h99;
        drive(1'b1, 32'd5, 32'h55, 1'b0, '0); tick();
        drive(1'b0, '0, '0, 1'b1, 32'd9);     tick();
        n_vec++;
        if (o_we !== 1'b0 || o_addr !== 32'd9) begin
            n_err++;
            $display("FAIL memrd_port: mem_we=%0b mem_addr=%h, required 0 9", o_we, o_addr);
        end
        drive(1'b0, '0, '0, 1'b0, '0);        tick();
        n_vec++;
        if (o_ldv !== 1'b1 || o_ldd !== 32'h99) begin
            n_err++;
            $display("FAIL memrd_data: valid=%0b data=%h, required 1 99", o_ldv, o_ldd);
        end
        wait_empty();
    endtask

    task automatic test_same_cycle();
        ram[32'd7]  = '0;
        arch[32'd7] = '0;
        drive(1'b1, 32'd7, 32'h77, 1'b1, 32'd7); tick();
        drive(1'b0, '0, '0, 1'b0, '0);           tick();
        n_vec += 2;
        if (o_ldv !== 1'b1 || o_ldd !== 32'h0) begin
            n_err++;
            $display("FAIL same_cycle_load: valid=%0b data=%h, required 1 0", o_ldv, o_ldd);
        end
        if (o_we !== 1'b1 || o_addr !== 32'd7 || o_wdata !== 32'h77) begin
            n_err++;
            $display("FAIL same_cycle_drain: we=%0b addr=%h data=%h, required 1 7 77",
                     o_we, o_addr, o_wdata);
        end
        wait_empty();
    endtask

    task automatic test_random();
        logic          sv;
        logic          lv;
        logic [AW-1:0] sa;
        logic [AW-1:0] la;
        logic [DW-1:0] sd;
        sv = 1'b0;
        sa = '0;
        sd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!sv && $urandom_range(0, 99) < 55) begin
                sv = 1'b1;
                sa = rand_addr();
                sd = $urandom();
            end
            lv = ($urandom_range(0, 99) < 40);
            la = rand_addr();
            drive(sv, sa, sd, lv, la);
            tick();
            n_vec += 3;
            if (o_ready !== e_ready || o_empty !== e_empty) begin
                n_err++;
                $display("FAIL rand_status cyc%0d: ready=%0b empty=%0b, required %0b %0b",
                         i, o_ready, o_empty, e_ready, e_empty);
            end
            if (o_we !== e_we || o_addr !== e_addr || (e_chkw && o_wdata !== e_wdata)) begin
                n_err++;
                $display("FAIL rand_port cyc%0d: we=%0b addr=%h data=%h, required we=%0b addr=%h data=%h",
                         i, o_we, o_addr, o_wdata, e_we, e_addr, e_wdata);
            end
            if (o_ldv !== e_ldv || o_ldd !== e_ldd) begin
                n_err++;
                $display("FAIL rand_load cyc%0d: valid=%0b data=%h, required %0b %h",
                         i, o_ldv, o_ldd, e_ldv, e_ldd);
            end
            if (accepted) sv = 1'b0;
        end
        wait_empty();
        foreach (arch[k]) begin
            n_vec++;
            if (rd_ram(k) !== arch[k]) begin
                n_err++;
                $display("FAIL rand_ram[%h]: %h, required %h", k, rd_ram(k), arch[k]);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        drive(1'b1, 32'h30, 32'hAAAA, 1'b1, 32'h31); tick();
        drive(1'b1, 32'h32, 32'hBBBB, 1'b1, 32'h31); tick();
        drive(1'b0, '0, '0, 1'b0, '0);
        #2;
        n_vec++;
        if (bus.mem_we !== 1'b1 || bus.ld_data_valid !== 1'b1) begin
            n_err++;
            $display("FAIL mid_drain_setup: mem_we=%0b ld_data_valid=%0b, required 1 1",
                     bus.mem_we, bus.ld_data_valid);
        end
        rst_n = 1'b0;
        #1;
        n_vec += 2;
        if (bus.mem_we !== 1'b0 || bus.empty !== 1'b1 || bus.st_ready !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset_status: mem_we=%0b empty=%0b st_ready=%0b, required 0 1 1",
                     bus.mem_we, bus.empty, bus.st_ready);
        end
        if (bus.ld_data_valid !== 1'b0 || bus.ld_data !== '0) begin
            n_err++;
            $display("FAIL async_reset_load: valid=%0b data=%h, required 0 0",
                     bus.ld_data_valid, bus.ld_data);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_vec++;
            if (o_we !== 1'b0) begin
                n_err++;
                $display("FAIL post_reset_we cyc%0d: mem_we=%0b addr=%h, required 0", i, o_we, o_addr);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_drain_order();
        test_load_hold();
        test_forward();
        test_mem_read();
        test_same_cycle();
        test_random();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_store_buffer.md
Name: data_store_buffer

Overview:
- Sits directly upstream of the data memory, between the MEM-stage load/store logic and the single shared RAM port.
- Accepts stores into a small in-order FIFO and drains them to memory on cycles when no load needs the port.
- Serves loads from memory, or forwards from the youngest matching buffered store, so loads never stall behind pending stores.
- Buffered entries are written to RAM in program order.

Parameters:
- DATA_WIDTH, 32, width of store data and of load return data.
- ADDR_WIDTH, 32, width of the word address passed unchanged to memory.
- DEPTH, 4, number of buffered stores; a power of 2, at least 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- st_valid  input  1  store request this cycle.
- st_ready  output  1  buffer can accept a store; equals (count < DEPTH).
- st_addr  input  ADDR_WIDTH  store word address.
- st_data  input  DATA_WIDTH  store data.
- ld_valid  input  1  load request this cycle.
- ld_addr  input  ADDR_WIDTH  load word address.
- ld_data  output  DATA_WIDTH  load result, valid when ld_data_valid is high.
- ld_data_valid  output  1  high exactly one cycle after an accepted load.
- flush  input  1  drain request; stays high until empty is seen.
- empty  output  1  count == 0.
- mem_we  output  1  to memory Write_Enable.
- mem_addr  output  ADDR_WIDTH  to memory Address.
- mem_wdata  output  DATA_WIDTH  to memory Write_Data.
- mem_rdata  input  DATA_WIDTH  from memory Read_Data; valid the cycle after the address is presented.

Behaviour:
- Reset values: count = 0, head = 0, tail = 0, ld_data_valid = 0, ld_data = 0, empty = 1, st_ready = 1. All buffered entries are discarded, including a reset mid-drain or mid-load.
- Store acceptance (st_valid && st_ready):
  - The entry {st_addr, st_data} is written at tail; tail increments modulo DEPTH; count increments.
  - st_valid while full is ignored. Upstream must hold the request until ready.
- Port arbitration is combinational each cycle, with the load having priority:
  - LOAD: ld_valid = 1. Drive mem_addr = ld_addr and mem_we = 0. No drain occurs this cycle.
  - DRAIN: ld_valid = 0 and count > 0. Drive mem_addr, mem_wdata from the head entry and mem_we = 1. Head increments modulo DEPTH; count decrements.
  - IDLE: drive mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Simultaneous store accept and drain in one cycle: count is unchanged; head and tail both advance.
- st_ready depends only on the registered count. No push-on-pop when full.
- Load forwarding, evaluated in the load cycle:
  - Compare ld_addr with every valid entry (the full ADDR_WIDTH must match).
  - The youngest match wins: scan from head toward tail and keep the last hit.
  - A store accepted in the same cycle as a load is younger than that load and is excluded from the search.
  - Register hit_q and fwd_data_q at the clock edge.
- Load response, the cycle after a load:
  - ld_data_valid = 1.
  - ld_data = fwd_data_q if hit_q, else mem_rdata.
  - The output is combinational from the registered select; it is zero when not valid.
- Back-to-back loads are allowed, one per cycle with 1-cycle latency. The drain is starved while loads continue.
- flush only affects empty reporting. Draining already proceeds every non-load cycle, and the requester waits for empty = 1.
- Pointers are clog2(DEPTH) bits wide and wrap naturally. count is clog2(DEPTH)+1 bits wide.

Decomposition:
- Shared header/package:
  - DATA_WIDTH and ADDR_WIDTH defaults, shared with the data memory.
  - Localparam PTR_W = clog2(DEPTH).
  - Arbitration encoding: ARB_IDLE, ARB_LOAD, ARB_DRAIN.
- One natural sub-module: store_buffer_match.
  - Purely combinational.
  - Inputs: entry arrays, head, count, query address.
  - Outputs: hit and youngest-match data.
- FIFO storage, pointers and arbitration stay in the top module.

Test Plan:
- Reset, then push 3 stores (addr 1, 2, 3 with data A1, B2, C3) and no loads -> mem_we pulses for 3 drain cycles in order 1, 2, 3; empty = 1 afterwards; a RAM dump matches.
- Hold ld_valid for 4 cycles while 4 stores are pushed -> st_ready = 0 after the 4th push, mem_we stays 0 throughout, and a 5th store is held off.
- Push store addr 5 data 11, then addr 5 data 22, then load addr 5 in the next cycle -> ld_data = 22 one cycle later and the memory read is ignored.
- Memory preloaded with addr 9 = 0x99, buffer holding addr 5 only, load addr 9 -> ld_data = 0x99 with 1-cycle latency; mem_we stays 0 in the load cycle.
- Store addr 7 data 0x77 and load addr 7 in the same cycle, memory addr 7 = 0 -> ld_data = 0 (the load is older), and the later drain writes 0x77.
- Assert reset low mid-drain with 2 entries pending -> outputs return to reset values immediately, and no further mem_we occurs.
